// File: rtl/y_update_pkg.sv
// Shared types and helpers for the Y matrix update engine.
// Mode codes, FSM states, word/slot mapping and saturating clamp.
package y_update_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_OVR = 2'b01;
  localparam logic [1:0] MODE_SUB = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_MODIFY,
    S_WRITE
  } state_t;

  function automatic int unsigned word_of(
    input int unsigned row,
    input int unsigned col,
    input int unsigned n,
    input int unsigned epw
  );
    return row * (n / epw) + col / epw;
  endfunction

  function automatic int unsigned slot_of(
    input int unsigned col,
    input int unsigned epw
  );
    return col % epw;
  endfunction

  // Clamp v into the signed range of a w-bit value.
  function automatic longint sat_clamp(
    input longint v,
    input int     w
  );
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/y_elem_alu.sv
// Combinational complex element update: add, subtract or overwrite.
// Add/subtract clamp each part to the signed element range.
module y_elem_alu
  import y_update_pkg::*;
#(
  parameter int ELEM_W = 24
) (
  input  logic [2*ELEM_W-1:0] old_val,
  input  logic [ELEM_W-1:0]   d_real,
  input  logic [ELEM_W-1:0]   d_img,
  input  logic [1:0]          mode,
  output logic [2*ELEM_W-1:0] new_val,
  output logic                sat
);

  longint o_re, o_im;
  longint x_re, x_im;
  longint r_re, r_im;
  longint c_re, c_im;

  // Widen, apply the operation, then clamp back to ELEM_W.
  always_comb begin
    o_re = longint'($signed(old_val[ELEM_W-1:0]));
    o_im = longint'($signed(old_val[2*ELEM_W-1:ELEM_W]));
    x_re = longint'($signed(d_real));
    x_im = longint'($signed(d_img));
    case (mode)
      MODE_OVR: begin
        r_re = x_re;
        r_im = x_im;
      end
      MODE_SUB: begin
        r_re = o_re - x_re;
        r_im = o_im - x_im;
      end
      default: begin
        r_re = o_re + x_re;
        r_im = o_im + x_im;
      end
    endcase
    c_re = sat_clamp(r_re, ELEM_W);
    c_im = sat_clamp(r_im, ELEM_W);
    sat = (c_re != r_re) || (c_im != r_im);
    new_val = {c_im[ELEM_W-1:0], c_re[ELEM_W-1:0]};
  end

endmodule

// File: rtl/y_update_engine.sv
// Read-modify-write engine applying change records to the Y SRAM.
// A last-word cache lets consecutive updates to one word skip the read.
module y_update_engine
  import y_update_pkg::*;
#(
  parameter int ELEM_W         = 24,
  parameter int ELEMS_PER_WORD = 4,
  parameter int WORD_W         = 256,
  parameter int N              = 64,
  parameter int ADDR_W         = 11
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_row,
  input  logic [15:0]         in_col,
  input  logic [ELEM_W-1:0]   in_real,
  input  logic [ELEM_W-1:0]   in_img,
  input  logic [1:0]          in_mode,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [WORD_W-1:0]   rd_data,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [WORD_W-1:0]   wr_data,
  output logic                out_valid,
  output logic [2*ELEM_W-1:0] out_yval,
  output logic                sat_flag,
  output logic                err_flag,
  output logic [15:0]         upd_count
);

  localparam int EW2 = 2 * ELEM_W;
  localparam int SLOT_W =
    (ELEMS_PER_WORD > 1) ? $clog2(ELEMS_PER_WORD) : 1;

  state_t              state;
  logic [ADDR_W-1:0]   word;
  logic [SLOT_W-1:0]   slot;
  logic [ELEM_W-1:0]   d_re;
  logic [ELEM_W-1:0]   d_im;
  logic [1:0]          mode;
  logic                hit;
  logic [ADDR_W-1:0]   cache_addr;
  logic [WORD_W-1:0]   cache_data;
  logic                cache_valid;

  logic                in_range;
  logic [ADDR_W-1:0]   in_word;
  logic [SLOT_W-1:0]   in_slot;
  logic [WORD_W-1:0]   src;
  logic [WORD_W-1:0]   nxt_word;
  logic [EW2-1:0]      old_elem;
  logic [EW2-1:0]      alu_val;
  logic                alu_sat;

  // Map the incoming record and splice the updated slot into the word.
  always_comb begin
    in_range = (32'(in_row) < N) && (32'(in_col) < N);
    in_word  = ADDR_W'(word_of(32'(in_row), 32'(in_col),
                               N, ELEMS_PER_WORD));
    in_slot  = SLOT_W'(slot_of(32'(in_col), ELEMS_PER_WORD));
    src      = hit ? cache_data : rd_data;
    old_elem = src[EW2*int'(slot) +: EW2];
    nxt_word = src;
    nxt_word[EW2*int'(slot) +: EW2] = alu_val;
  end

  y_elem_alu #(
    .ELEM_W (ELEM_W)
  ) u_alu (
    .old_val (old_elem),
    .d_real  (d_re),
    .d_img   (d_im),
    .mode    (mode),
    .new_val (alu_val),
    .sat     (alu_sat)
  );

  // Control FSM with registered SRAM and status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      word        <= '0;
      slot        <= '0;
      d_re        <= '0;
      d_im        <= '0;
      mode        <= MODE_ADD;
      hit         <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= '0;
      cache_valid <= 1'b0;
      rd_addr     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      out_valid   <= 1'b0;
      out_yval    <= '0;
      sat_flag    <= 1'b0;
      err_flag    <= 1'b0;
      upd_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            in_ready <= 1'b0;
            if (!in_range) begin
              err_flag <= 1'b1;
            end else begin
              word <= in_word;
              slot <= in_slot;
              d_re <= in_real;
              d_im <= in_img;
              mode <= in_mode;
              if (cache_valid && cache_addr == in_word) begin
                hit   <= 1'b1;
                state <= S_MODIFY;
              end else begin
                hit     <= 1'b0;
                rd_addr <= in_word;
                state   <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          state <= S_MODIFY;
        end
        S_MODIFY: begin
          wr_en     <= 1'b1;
          wr_addr   <= word;
          wr_data   <= nxt_word;
          out_valid <= 1'b1;
          out_yval  <= alu_val;
          if (alu_sat) sat_flag <= 1'b1;
          state     <= S_WRITE;
        end
        S_WRITE: begin
          wr_en       <= 1'b0;
          out_valid   <= 1'b0;
          cache_addr  <= word;
          cache_data  <= wr_data;
          cache_valid <= 1'b1;
          upd_count   <= upd_count + 16'd1;
          in_ready    <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y_update_engine.sv
// Directed-vector bench for y_update_engine with a write-first SRAM model.
// Vectors carry hand-computed results; corner cases use short sequences.
module tb_y_update_engine;

  localparam int ELEM_W = 24;
  localparam int EPW    = 4;
  localparam int WORD_W = 256;
  localparam int N      = 64;
  localparam int ADDR_W = 11;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] OVR = 2'b01;
  localparam logic [1:0] SUB = 2'b10;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [15:0]         in_row = '0;
  logic [15:0]         in_col = '0;
  logic [ELEM_W-1:0]   in_real = '0;
  logic [ELEM_W-1:0]   in_img = '0;
  logic [1:0]          in_mode = '0;
  logic [ADDR_W-1:0]   rd_addr;
  logic [WORD_W-1:0]   rd_data = '0;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WORD_W-1:0]   wr_data;
  logic                out_valid;
  logic [2*ELEM_W-1:0] out_yval;
  logic                sat_flag;
  logic                err_flag;
  logic [15:0]         upd_count;

  y_update_engine #(
    .ELEM_W         (ELEM_W),
    .ELEMS_PER_WORD (EPW),
    .WORD_W         (WORD_W),
    .N              (N),
    .ADDR_W         (ADDR_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_col    (in_col),
    .in_real   (in_real),
    .in_img    (in_img),
    .in_mode   (in_mode),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .out_valid (out_valid),
    .out_yval  (out_yval),
    .sat_flag  (sat_flag),
    .err_flag  (err_flag),
    .upd_count (upd_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int wr_seen = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (wr_en) wr_seen <= wr_seen + 1;

  // Write-first SRAM model with a bench-side preload port.
  logic [WORD_W-1:0] mem [0:2047];
  logic              ld_en = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [WORD_W-1:0] ld_data = '0;

  always @(posedge clock) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
  end

  typedef struct {
    int         row;
    int         col;
    int         re;
    int         im;
    logic [1:0] mode;
    int         addr;
    int         ere;
    int         eim;
    bit         hit;
    bit         sat;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [47:0] mk(input int re, input int im);
    return {im[23:0], re[23:0]};
  endfunction

  function automatic logic [WORD_W-1:0] put(
    input logic [WORD_W-1:0] w, input int s, input int re, input int im
  );
    logic [WORD_W-1:0] r;
    r = w;
    r[48*s +: 48] = mk(re, im);
    return r;
  endfunction

  task automatic chk(
    input string nm, input logic [WORD_W-1:0] act,
    input logic [WORD_W-1:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input int a, input logic [WORD_W-1:0] d);
    @(negedge clock);
    ld_en = 1'b1;
    ld_addr = ADDR_W'(a);
    ld_data = d;
    @(posedge clock);
    #1 ld_en = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    in_row   = 16'(v.row);
    in_col   = 16'(v.col);
    in_real  = ELEM_W'(v.re);
    in_img   = ELEM_W'(v.im);
    in_mode  = v.mode;
    in_valid = 1'b1;
  endtask

  // Send one record, wait for its write, check result and timing.
  task automatic run_vec(input vec_t v, input int idx, input int exp_cnt);
    logic [ADDR_W-1:0] rd0;
    int acc;
    bit got;
    string p;
    p = $sformatf("v%0d", idx);
    rd0 = rd_addr;
    drive(v);
    for (int k = 0; k < 10; k++) begin
      if (in_ready) break;
      @(negedge clock);
    end
    if (!in_ready) begin
      chk({p, "_ready_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
    acc = cyc;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (wr_en) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk({p, "_write_timeout"}, 0, 1);
      return;
    end
    chk({p, "_wr_addr"}, wr_addr, v.addr);
    chk({p, "_out_valid"}, out_valid, 1);
    chk({p, "_yval"}, out_yval, mk(v.ere, v.eim));
    chk({p, "_latency"}, cyc - acc, v.hit ? 1 : 2);
    chk({p, "_rd_addr"}, rd_addr, v.hit ? rd0 : ADDR_W'(v.addr));
    chk({p, "_sat"}, sat_flag, v.sat);
    @(negedge clock);
    chk({p, "_count"}, upd_count, exp_cnt);
    chk({p, "_wr_drop"}, wr_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vr;
    vec_t ve;
    logic [WORD_W-1:0] pad;
    int ws;

    tbl[0] = '{2, 5, 23, 7, ADD, 33, 123, -43, 1'b0, 1'b0};
    tbl[1] = '{2, 6, 5, -3, ADD, 33, 5, -3, 1'b1, 1'b0};
    tbl[2] = '{3, 3, -1, 1, OVR, 48, -1, 1, 1'b0, 1'b0};
    tbl[3] = '{3, 3, 1, 1, SUB, 48, -2, 0, 1'b1, 1'b0};
    tbl[4] = '{10, 20, 'h20, 0, ADD, 165, 'h7FFFFF, 0, 1'b0, 1'b1};
    tbl[5] = '{10, 21, 'h20, 0, SUB, 165, -'h800000, 5, 1'b1, 1'b1};
    tbl[6] = '{0, 63, -5, 9, 2'b11, 15, -5, 9, 1'b0, 1'b1};
    tbl[7] = '{63, 0, 'h123456, -'h654321, OVR, 1008,
               'h123456, -'h654321, 1'b0, 1'b1};

    pad = '0;
    pad[255:192] = 64'hA5A5_5A5A_0123_4567;
    load(33, put(put(put(pad, 0, 11, 22), 1, 100, -50), 3, 7, 8));
    load(48, '0);
    load(165, put(put('0, 0, 'h7FFFF0, 0), 1, -'h7FFFF0, 5));
    load(15, '0);
    load(1008, '0);

    @(negedge clock);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_yval", out_yval, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_flags", {sat_flag, err_flag}, 0);
    chk("rst_count", upd_count, 0);
    reset = 1'b1;
    @(posedge clock);
    #1 chk("rel_in_ready", in_ready, 1);
    @(negedge clock);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i, i + 1);

    chk("word33_final", mem[33],
        put(put(put(put(pad, 0, 11, 22), 1, 123, -43), 2, 5, -3),
            3, 7, 8));
    chk("word165_final", mem[165],
        put(put('0, 0, 'h7FFFFF, 0), 1, -'h800000, 5));

    // Out-of-range row is dropped with a one-cycle in_ready gap.
    ve = '{64, 0, 1, 1, ADD, 0, 0, 0, 1'b0, 1'b0};
    ws = wr_seen;
    drive(ve);
    @(posedge clock);
    #1 in_valid = 1'b0;
    chk("err_ready_low", in_ready, 0);
    chk("err_flag", err_flag, 1);
    @(posedge clock);
    #1 chk("err_ready_back", in_ready, 1);
    repeat (3) @(negedge clock);
    chk("err_no_write", wr_seen, ws);
    chk("err_count", upd_count, 8);

    // Reset while a cache-hit record sits in MODIFY.
    vr = '{63, 1, 1, 1, ADD, 1008, 1, 1, 1'b0, 1'b0};
    drive(vr);
    @(posedge clock);
    #1 in_valid = 1'b0;
    ws = wr_seen;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_count", upd_count, 0);
    repeat (2) @(negedge clock);
    chk("mid_rst_no_write", wr_seen, ws);
    reset = 1'b1;
    @(posedge clock);
    #1 chk("mid_rel_ready", in_ready, 1);
    chk("mid_rel_flags", {sat_flag, err_flag}, 0);
    @(negedge clock);
    run_vec(vr, 8, 1);
    chk("word1008_final", mem[1008],
        put(put('0, 0, 'h123456, -'h654321), 1, 1, 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
